// File: rtl/pull_responder_fifo.sv
// pull_responder_fifo: push-fed FIFO that answers a level req with one-cycle ack
// and the head word on dout.
//
// Ports:
//   clk, rst                 sync active-high reset
//   wr_en, wr_data           push side
//   full, empty, level       occupancy
//   overflow                 sticky dropped-push flag
//   req, ack, dout           pull handshake
//   count                    words served
//   stall_count              starved cycles (macro PULL_RESP_STALL_STATS_EN)
module pull_responder_fifo #(
  parameter int                    data_width    = 32,
  parameter int                    depth_log2    = 3,
  parameter logic [data_width-1:0] initial_value = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [depth_log2:0]   level,
  output logic                  overflow,
  input  logic                  req,
  output logic                  ack,
  output logic [data_width-1:0] dout,
  output logic [31:0]           count
`ifdef PULL_RESP_STALL_STATS_EN
  ,
  output logic [31:0]           stall_count
`endif
);

  localparam int DEPTH = 1 << depth_log2;
  localparam logic [depth_log2:0] FULL_LVL =
    {1'b1, {depth_log2{1'b0}}};

  logic [data_width-1:0] mem [DEPTH];

  logic [depth_log2-1:0] wr_ptr_q, wr_ptr_d;
  logic [depth_log2-1:0] rd_ptr_q, rd_ptr_d;
  logic [depth_log2:0]   level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  ack_q, ack_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic [31:0]           count_q, count_d;

  logic push;
  logic serve;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);

  // full is the registered view, so a same-cycle serve
  // does not make room for a push.
  assign push  = wr_en & ~full;
  // ~ack_q keeps the still-high req during the ack cycle
  // from being served twice.
  assign serve = req & ~ack_q & ~empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    ack_d      = serve;
    dout_d     = dout_q;
    count_d    = count_q;

    if (push)
      wr_ptr_d = wr_ptr_q + depth_log2'(1);
    if (wr_en & full)
      overflow_d = 1'b1;

    if (serve) begin
      dout_d   = mem[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + depth_log2'(1);
      count_d  = count_q + 32'd1;
    end

    if (push & ~serve)
      level_d = level_q + (depth_log2+1)'(1);
    else if (serve & ~push)
      level_d = level_q - (depth_log2+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      ack_q      <= 1'b0;
      dout_q     <= initial_value;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
      count_q    <= count_d;
    end
  end

  // Storage is not reset; a flush just rewinds the pointers.
  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wr_ptr_q] <= wr_data;
  end

  assign level    = level_q;
  assign overflow = overflow_q;
  assign ack      = ack_q;
  assign dout     = dout_q;
  assign count    = count_q;

`ifdef PULL_RESP_STALL_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (req & ~ack_q & empty)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_pull_responder_fifo.sv
// tb_pull_responder_fifo: directed bench for pull_responder_fifo
// (depth_log2=2, initial_value=DEADBEEF).
module tb_pull_responder_fifo;

  localparam logic [31:0] INIT = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  logic        empty;
  logic [2:0]  level;
  logic        overflow;
  logic        req;
  logic        ack;
  logic [31:0] dout;
  logic [31:0] count;
`ifdef PULL_RESP_STALL_STATS_EN
  logic [31:0] stall_count;
  logic [31:0] stall_base;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q [$];

  pull_responder_fifo #(
    .data_width   (32),
    .depth_log2   (2),
    .initial_value(INIT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .overflow(overflow),
    .req     (req),
    .ack     (ack),
    .dout    (dout),
    .count   (count)
`ifdef PULL_RESP_STALL_STATS_EN
    ,
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    tick();
    wr_en   = 1'b0;
  endtask

  // Holds req and checks each served word against exp_q.
  task automatic collect(input int n, input int budget);
    int   got;
    logic prev;
    got  = 0;
    prev = 1'b0;
    req  = 1'b1;
    for (int c = 0; c < budget && got < n; c++) begin
      tick();
      if (ack) begin
        chk("ack_gap", 32'(prev), 32'd0);
        chk("dout", dout, exp_q.pop_front());
        got++;
      end
      prev = ack;
    end
    req = 1'b0;
    chk("served", 32'(got), 32'(n));
  endtask

  initial begin
    int acks;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    req     = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dout", dout, INIT);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_count", count, 32'd0);
`ifdef PULL_RESP_STALL_STATS_EN
    chk("rst_stall", stall_count, 32'd0);
`endif

    // Basic serve
    push(5); push(6); push(7);
    chk("b_level", 32'(level), 32'd3);
    exp_q = '{32'd5, 32'd6, 32'd7};
    collect(3, 20);
    chk("b_count", count, 32'd3);
    chk("b_empty", 32'(empty), 32'd1);
    tick();

    // Starvation
`ifdef PULL_RESP_STALL_STATS_EN
    stall_base = stall_count;
`endif
    req  = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack) acks++;
    end
    chk("s_noack", 32'(acks), 32'd0);
    push(42);
    chk("s_ack_n", 32'(ack), 32'd0);
    tick();
    chk("s_ack_n1", 32'(ack), 32'd1);
    chk("s_dout", dout, 32'd42);
`ifdef PULL_RESP_STALL_STATS_EN
    chk("s_stall", stall_count - stall_base, 32'd11);
`endif
    req = 1'b0;
    tick();

    // Full and overflow
    push(1); push(2); push(3);
    chk("f_full3", 32'(full), 32'd0);
    push(4);
    chk("f_full", 32'(full), 32'd1);
    chk("f_level", 32'(level), 32'd4);
    chk("f_ovf0", 32'(overflow), 32'd0);
    push(5);
    chk("f_ovf", 32'(overflow), 32'd1);
    chk("f_level5", 32'(level), 32'd4);
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    collect(4, 20);
    req  = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack) acks++;
    end
    req = 1'b0;
    chk("f_nomore", 32'(acks), 32'd0);
    chk("f_count", count, 32'd8);

    // Wrap-around
    for (int i = 0; i < 10; i++) begin
      push(32'(100 + i));
      chk("w_level", 32'(level), 32'd1);
      exp_q.push_back(32'(100 + i));
      collect(1, 6);
      tick();
    end

    // Simultaneous push and serve
    push(200); push(201);
    chk("p_level2", 32'(level), 32'd2);
    req     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 202;
    tick();
    wr_en = 1'b0;
    req   = 1'b0;
    chk("p_level", 32'(level), 32'd2);
    chk("p_ack", 32'(ack), 32'd1);
    chk("p_dout", dout, 32'd200);
    tick();
    exp_q = '{32'd201, 32'd202};
    collect(2, 10);
    tick();

    // Reset mid-operation
    push(11); push(12); push(13); push(14);
    req = 1'b1;
    tick();
    chk("r_ack1", 32'(ack), 32'd1);
    chk("r_level3", 32'(level), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 1'b0;
    chk("r_ack", 32'(ack), 32'd0);
    chk("r_dout", dout, INIT);
    chk("r_level", 32'(level), 32'd0);
    chk("r_count", count, 32'd0);
    chk("r_ovf", 32'(overflow), 32'd0);
    chk("r_empty", 32'(empty), 32'd1);
    push(9);
    exp_q = '{32'd9};
    collect(1, 6);
    chk("r_count1", count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
